// File: rtl/tiny_dnn_pkg.sv
// Shared widths, state encoding and beat layout for the tiny_dnn result path.
package tiny_dnn_pkg;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 32;
    localparam int STALL_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } dst_state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } dst_beat_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/dst_skid_fifo.sv
// Circular skid FIFO holding returned beats until the stream sink accepts them.
module dst_skid_fifo
    import tiny_dnn_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 33,
    localparam int CNT_W = cnt_w(DEPTH),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = bump(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = bump(rd_ptr_q);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            store_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = store_q[rd_ptr_q];
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/dst_stream_ctrl.sv
// Streams result-buffer words 0..ds out over AXI-Stream with credit-based reads.
// Define DST_STALL_CNT_EN to add the stall_cnt back-pressure counter port.
module dst_stream_ctrl
    import tiny_dnn_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] ds,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_a,
    input  logic [DATA_W-1:0] mem_d,
    output logic [DATA_W-1:0] dst_data,
    output logic              dst_valid,
    input  logic              dst_ready,
    output logic              dst_last,
    output logic              busy,
    output logic              done
`ifdef DST_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0] stall_cnt
`endif
);

    localparam int CNT_W = cnt_w(DEPTH);

    dst_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ds_q, ds_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] tag_q, tag_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              credit_ok;
    logic              issue;
    logic              push;
    logic              pop;
    dst_beat_t         push_beat;
    dst_beat_t         pop_beat;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(vld_q[i]);
        end
    end

    // Reserve a FIFO slot for every read in flight so a push never overflows.
    assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count})
                       < (CNT_W + 1)'(DEPTH);
    assign issue     = (state_q == ST_ISSUE) && credit_ok;

    always_comb begin
        state_d = state_q;
        ds_d    = ds_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    ds_d    = ds;
                    addr_d  = '0;
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    if (addr_q == ds_q) begin
                        state_d = ST_DRAIN;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && pop_beat.last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Valid/tag pipeline lines each return up with its read, RD_LAT cycles on.
    always_comb begin
        vld_d    = vld_q;
        tag_d    = tag_q;
        vld_d[0] = issue;
        tag_d[0] = issue && (addr_q == ds_q);
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ds_q    <= '0;
            addr_q  <= '0;
            vld_q   <= '0;
            tag_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ds_q    <= ds_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            tag_q   <= tag_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        push_beat      = '0;
        push_beat.last = tag_q[RD_LAT-1];
        push_beat.data = mem_d;
    end

    assign push = vld_q[RD_LAT-1] && !fifo_full;
    assign pop  = !fifo_empty && dst_ready;

    dst_skid_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(dst_beat_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_beat),
        .pop       (pop),
        .pop_data  (pop_beat),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign mem_re    = issue;
    assign mem_a     = addr_q;
    assign dst_valid = !fifo_empty;
    assign dst_data  = fifo_empty ? '0 : pop_beat.data;
    assign dst_last  = !fifo_empty && pop_beat.last;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

`ifdef DST_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_IDLE) && start) begin
            stall_d = '0;
        end else if (dst_valid && !dst_ready && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_dst_stream_ctrl.sv
// Self-checking bench for dst_stream_ctrl against a queue-free beat/address model.
// Define DST_STALL_CNT_EN to also check the stall counter.
module tb_dst_stream_ctrl;

    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] ds_in = '0;
    logic        mem_re;
    logic [11:0] mem_a;
    logic [31:0] mem_d;
    logic [31:0] dst_data;
    logic        dst_valid;
    logic        dst_ready = 1'b0;
    logic        dst_last;
    logic        busy;
    logic        done;
`ifdef DST_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [4096];
    logic [11:0] pa [RD_LAT];
    logic        pv [RD_LAT];
    logic [31:0] junk;

    always #5 clk = ~clk;

    dst_stream_ctrl #(
        .RD_LAT (RD_LAT),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ds        (ds_in),
        .mem_re    (mem_re),
        .mem_a     (mem_a),
        .mem_d     (mem_d),
        .dst_data  (dst_data),
        .dst_valid (dst_valid),
        .dst_ready (dst_ready),
        .dst_last  (dst_last),
        .busy      (busy),
        .done      (done)
`ifdef DST_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // Result buffer: data for address A appears RD_LAT cycles after the strobe.
    always @(posedge clk) begin
        pv[0] <= mem_re;
        pa[0] <= mem_a;
        for (int i = 1; i < RD_LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
        junk <= $urandom;
    end

    assign mem_d = pv[RD_LAT-1] ? mem[pa[RD_LAT-1]] : junk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 4096; i++) begin
            mem[i] = $urandom;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mem_re"}, 32'(mem_re), 32'd0);
        chk({tag, ".mem_a"}, 32'(mem_a), 32'd0);
        chk({tag, ".valid"}, 32'(dst_valid), 32'd0);
        chk({tag, ".last"}, 32'(dst_last), 32'd0);
        chk({tag, ".data"}, dst_data, 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
`ifdef DST_STALL_CNT_EN
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'd0);
`endif
    endtask

    // mode: 0 ready high, 1 ready 1,0,0 pattern, 2 random, 3 five stalls
    task automatic run_burst(input logic [11:0] ds, input int mode,
                             input int rst_after, input int restart_cyc);
        int cyc, beats, issued, last_cyc, first_cyc, max_out, stalls, lowcnt;
        logic prev_stall, prev_last, rdy;
        logic [31:0] prev_data;
        beats = 0; issued = 0; last_cyc = -1; first_cyc = -1;
        max_out = 0; stalls = 0; lowcnt = 0;
        prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
        ds_in = ds;
        start = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (cyc < 2000) begin
            if (rst_after > 0 && beats == rst_after) begin
                start = 1'b0;
                rst = 1'b1;
                #1;
                chk_all_zero("midrst");
                @(negedge clk);
                rst = 1'b0;
                dst_ready = 1'b0;
                @(negedge clk);
                chk("midrst.idle", 32'(busy), 32'd0);
                return;
            end
            start = (cyc == restart_cyc);
            if (start) ds_in = ds + 12'd5;
            chk("done", 32'(done), 32'(last_cyc >= 0 && cyc == last_cyc + 1));
            if (done) break;
            chk("busy", 32'(busy), 32'd1);
            if (prev_stall) begin
                chk("hold.valid", 32'(dst_valid), 32'd1);
                chk("hold.data", dst_data, prev_data);
                chk("hold.last", 32'(dst_last), 32'(prev_last));
            end
            if (mem_re) begin
                chk("mem_a", 32'(mem_a), 32'(issued));
                issued++;
            end
            if (issued - beats > max_out) max_out = issued - beats;
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (cyc % 3) == 1;
                2: rdy = 1'($urandom_range(0, 1));
                default: rdy = !(dst_valid && lowcnt < 5);
            endcase
            dst_ready = rdy;
            if (dst_valid && rdy) begin
                if (first_cyc < 0) first_cyc = cyc;
                chk("data", dst_data, mem[beats]);
                chk("last", 32'(dst_last), 32'(beats == 32'(ds)));
                if (beats == 32'(ds)) last_cyc = cyc;
                beats++;
            end
            if (dst_valid && !rdy) begin
                stalls++;
                lowcnt++;
            end
            prev_stall = dst_valid && !rdy;
            prev_data = dst_data;
            prev_last = dst_last;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        dst_ready = 1'b0;
        chk("timeout", 32'(cyc < 2000), 32'd1);
        chk("beats", 32'(beats), 32'(ds) + 32'd1);
        chk("issued", 32'(issued), 32'(ds) + 32'd1);
        chk("credit", 32'(max_out <= DEPTH), 32'd1);
        chk("idle_at_done", 32'(busy), 32'd0);
        if (mode == 0) begin
            chk("first_lat", 32'(first_cyc), 32'(RD_LAT + 2));
            chk("rate", 32'(last_cyc - first_cyc), 32'(ds));
        end
`ifdef DST_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(stalls));
`endif
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("no_extra", 32'(dst_valid), 32'd0);
    endtask

    initial begin
        fill_mem();
        #2;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset.busy", 32'(busy), 32'd0);

        run_burst(12'd7, 0, 0, 0);
        run_burst(12'd15, 1, 0, 0);
        run_burst(12'd0, 0, 0, 0);
        run_burst(12'd31, 0, 10, 0);
        fill_mem();
        run_burst(12'd3, 0, 0, 0);
        run_burst(12'd9, 0, 0, 5);
        run_burst(12'd3, 3, 0, 0);
        for (int r = 0; r < 4; r++) begin
            fill_mem();
            run_burst(12'($urandom_range(1, 40)), 2, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
